// File: rtl/test_r4_pkg.sv
// test_r4_pkg: shared constants for the radius-4 box-sum engine.
// Window geometry, sum width and the exact rounded-mean helper live here
// so the top and the line-buffer agree on pixel/sum widths.
package test_r4_pkg;

  localparam int DATA_W = 8;
  localparam int R      = 4;
  localparam int K      = 2 * R + 1;
  localparam int SUM_W  = DATA_W + 7;

  // Rounded mean = floor((sum + 40) / 81). The division is replaced by a
  // multiply by ceil(2^21/81) = 25891 and a 21-bit shift. The error term
  // (25891*81 - 2^21 = 19) stays below 2^(21-15), so the result is exact for
  // every 15-bit dividend, which covers 20655 + 40.
  localparam int MEAN_RND   = 40;
  localparam int MEAN_DIV   = 81;
  localparam int MEAN_SHIFT = 21;
  localparam int MEAN_MUL   = ((2 ** MEAN_SHIFT) + MEAN_DIV - 1) / MEAN_DIV;

  function automatic logic [DATA_W-1:0] mean_of(input logic [SUM_W-1:0] s);
    logic [39:0] prod;
    prod = (40'(s) + 40'(MEAN_RND)) * 40'(MEAN_MUL);
    return DATA_W'(prod >> MEAN_SHIFT);
  endfunction

endpackage

// File: rtl/r4_line_buffer.sv
// r4_line_buffer: one image line of pixel delay, advancing only when en_i=1.
// Output is the pixel written DEPTH accepted pixels ago (read-before-write).
// Contents are not reset; only the circular pointer is.
module r4_line_buffer
  import test_r4_pkg::*;
#(
  parameter int W     = DATA_W,
  parameter int DEPTH = 30
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic [W-1:0] dat_i,
  output logic [W-1:0] dat_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;

  // The slot about to be overwritten holds the oldest pixel: that is the output.
  assign dat_o = mem_q[ptr_q];

  // Pointer wraps at DEPTH-1 so the delay is exactly one line.
  always_comb begin
    ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
  end

  // Pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (en_i) begin
      ptr_q <= ptr_d;
    end
  end

  // Storage write, no reset needed.
  always_ff @(posedge clk) begin
    if (en_i) begin
      mem_q[ptr_q] <= dat_i;
    end
  end

endmodule

// File: rtl/test_r4.sv
// test_r4: streaming 9x9 box-sum over raster-order 8-bit pixels, one per clock.
// Latency 2 cycles from accepted pixel to sum_o/valid_o (3 with TEST_R4_MEAN_EN,
// which adds mean_o). No backpressure: done_i=1 means a pixel every cycle.
module test_r4
  import test_r4_pkg::*;
#(
  parameter int IMG_W = 30,
  parameter int IMG_H = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] grayscale_i,
  input  logic              done_i,
`ifdef TEST_R4_MEAN_EN
  output logic [DATA_W-1:0] mean_o,
`endif
  output logic [SUM_W-1:0]  sum_o,
  output logic              valid_o,
  output logic              done_o
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int RS_W  = DATA_W + 4;

  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [DATA_W-1:0] lb_in  [2*R];
  logic [DATA_W-1:0] lb_out [2*R];
  logic [DATA_W-1:0] tap    [K];
  logic [DATA_W-1:0] win_q  [K][K];
  logic              win_vld_d, win_last_d, win_vld_q, win_last_q;
  logic [RS_W-1:0]   rsum_d [K];
  logic [RS_W-1:0]   rsum_q [K];
  logic              rs_vld_q, rs_last_q;
  logic [SUM_W-1:0]  sum_d, sum_q;
  logic              vld_q, last_q;

  // Raster position of the incoming pixel; a low done_i aborts back to (0,0).
  always_comb begin
    col_d = '0;
    row_d = '0;
    if (done_i) begin
      if (col_q == COL_W'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (row_q == ROW_W'(IMG_H - 1)) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
        row_d = row_q;
      end
    end
  end

  // Position counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Cascaded line buffers: tap[K-1] is the current row, tap[0] is eight rows up.
  assign tap[K-1] = grayscale_i;
  for (genvar i = 0; i < 2 * R; i++) begin : g_lb
    if (i == 0) begin : g_head
      assign lb_in[i] = grayscale_i;
    end else begin : g_chain
      assign lb_in[i] = lb_out[i-1];
    end
    r4_line_buffer #(.W(DATA_W), .DEPTH(IMG_W)) u_lb (
      .clk   (clk),
      .rst   (rst),
      .en_i  (done_i),
      .dat_i (lb_in[i]),
      .dat_o (lb_out[i])
    );
    assign tap[K-2-i] = lb_out[i];
  end

  // A window is complete once its bottom-right pixel sits fully inside the frame.
  always_comb begin
    win_vld_d  = done_i && (row_q >= ROW_W'(K - 1)) && (col_q >= COL_W'(K - 1));
    win_last_d = win_vld_d && (row_q == ROW_W'(IMG_H - 1)) && (col_q == COL_W'(IMG_W - 1));
  end

  // Window shifts one column left per accepted pixel; newest column enters at K-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          win_q[r][c] <= '0;
        end
      end
      win_vld_q  <= 1'b0;
      win_last_q <= 1'b0;
    end else begin
      if (done_i) begin
        for (int r = 0; r < K; r++) begin
          for (int c = 0; c < K - 1; c++) begin
            win_q[r][c] <= win_q[r][c+1];
          end
          win_q[r][K-1] <= tap[r];
        end
      end
      win_vld_q  <= win_vld_d;
      win_last_q <= win_last_d;
    end
  end

  // First adder stage: one sum per window row.
  always_comb begin
    for (int r = 0; r < K; r++) begin
      rsum_d[r] = '0;
      for (int c = 0; c < K; c++) begin
        rsum_d[r] = rsum_d[r] + RS_W'(win_q[r][c]);
      end
    end
  end

  // Row sums register; flags follow regardless so the pipeline drains after an abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < K; r++) begin
        rsum_q[r] <= '0;
      end
      rs_vld_q  <= 1'b0;
      rs_last_q <= 1'b0;
    end else begin
      if (win_vld_q) begin
        rsum_q <= rsum_d;
      end
      rs_vld_q  <= win_vld_q;
      rs_last_q <= win_last_q;
    end
  end

  // Second adder stage: total of the row sums.
  always_comb begin
    sum_d = '0;
    for (int r = 0; r < K; r++) begin
      sum_d = sum_d + SUM_W'(rsum_q[r]);
    end
  end

  // Sum register holds its value between valid windows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q  <= '0;
      vld_q  <= 1'b0;
      last_q <= 1'b0;
    end else begin
      if (rs_vld_q) begin
        sum_q <= sum_d;
      end
      vld_q  <= rs_vld_q;
      last_q <= rs_last_q;
    end
  end

`ifdef TEST_R4_MEAN_EN
  logic [SUM_W-1:0]  sum_m_q;
  logic [DATA_W-1:0] mean_q;
  logic              vld_m_q, last_m_q;

  // Extra stage for the mean multiply; sum is delayed alongside to stay aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_m_q  <= '0;
      mean_q   <= '0;
      vld_m_q  <= 1'b0;
      last_m_q <= 1'b0;
    end else begin
      if (vld_q) begin
        sum_m_q <= sum_q;
        mean_q  <= mean_of(sum_q);
      end
      vld_m_q  <= vld_q;
      last_m_q <= last_q;
    end
  end

  assign sum_o   = sum_m_q;
  assign mean_o  = mean_q;
  assign valid_o = vld_m_q;
  assign done_o  = last_m_q;
`else
  assign sum_o   = sum_q;
  assign valid_o = vld_q;
  assign done_o  = last_q;
`endif

endmodule

// File: tb/tb_test_r4.sv
// tb_test_r4: directed frames through test_r4 with hand-derived expected sums.
// Patterns: all-1, all-255, pixel=col, pixel=row, abort after 16 rows, reset mid-frame.
module tb_test_r4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        done_i = 1'b0;
  logic [7:0]  gray = 8'd0;
  logic [14:0] sum_o;
  logic        valid_o;
  logic        done_o;
`ifdef TEST_R4_MEAN_EN
  logic [7:0]  mean_o;
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  test_r4 dut (
    .clk         (clk),
    .rst         (rst),
    .grayscale_i (gray),
    .done_i      (done_i),
`ifdef TEST_R4_MEAN_EN
    .mean_o      (mean_o),
`endif
    .sum_o       (sum_o),
    .valid_o     (valid_o),
    .done_o      (done_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int sums[$];
  int means[$];
  int done_idx[$];
  int first_cyc = -1;
  int acc88 = 0;
  int tests = 0;
  int fails = 0;

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (valid_o) begin
      if (sums.size() == 0) first_cyc = cyc;
      sums.push_back(int'(sum_o));
`ifdef TEST_R4_MEAN_EN
      means.push_back(int'(mean_o));
`endif
      if (done_o) done_idx.push_back(sums.size() - 1);
    end else if (done_o) begin
      done_idx.push_back(-1);
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int pix(input int pat, input int r, input int c);
    case (pat)
      0:       return 1;
      1:       return 255;
      2:       return c;
      default: return r;
    endcase
  endfunction

  function automatic int exp_sum(input int pat, input int r, input int c);
    case (pat)
      0:       return 81;
      1:       return 20655;
      2:       return 81 * c - 324;
      default: return 81 * r - 324;
    endcase
  endfunction

  task automatic clear_mon();
    @(posedge clk);
    sums.delete();
    means.delete();
    done_idx.delete();
    first_cyc = -1;
  endtask

  task automatic drive_rows(input int pat, input int nrows);
    for (int r = 0; r < nrows; r++) begin
      for (int c = 0; c < 30; c++) begin
        @(negedge clk);
        done_i = 1'b1;
        gray   = 8'(pix(pat, r, c));
        if (r == 8 && c == 8) acc88 = cyc;
      end
    end
  endtask

  task automatic send_rows(input int pat, input int nrows);
    drive_rows(pat, nrows);
    @(negedge clk);
    done_i = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic check_frame(input string tag, input int pat);
    int nbad;
    int nbad_m;
    chk({tag, " count"}, sums.size(), 484);
    nbad   = 0;
    nbad_m = 0;
    for (int i = 0; i < sums.size() && i < 484; i++) begin
      if (sums[i] != exp_sum(pat, 8 + i / 22, 8 + i % 22)) nbad++;
`ifdef TEST_R4_MEAN_EN
      if (means[i] != (exp_sum(pat, 8 + i / 22, 8 + i % 22) + 40) / 81) nbad_m++;
`endif
    end
    chk({tag, " bad sums"}, nbad, 0);
`ifdef TEST_R4_MEAN_EN
    chk({tag, " bad means"}, nbad_m, 0);
`endif
    chk({tag, " latency"}, first_cyc - acc88, LAT + 1);
    chk({tag, " done count"}, done_idx.size(), 1);
    chk({tag, " done pos"}, (done_idx.size() > 0) ? done_idx[0] : -2, 483);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset sum", int'(sum_o), 0);
    chk("reset valid", int'(valid_o), 0);
    chk("reset done", int'(done_o), 0);
    rst = 1'b0;

    // All ones.
    clear_mon();
    send_rows(0, 30);
    check_frame("ones", 0);
    chk("ones first", (sums.size() > 0) ? sums[0] : -1, 81);

    // All 255: maximum sum, mean 255.
    clear_mon();
    send_rows(1, 30);
    check_frame("max", 1);
    chk("max first", (sums.size() > 0) ? sums[0] : -1, 20655);
`ifdef TEST_R4_MEAN_EN
    chk("max mean", (means.size() > 0) ? means[0] : -1, 255);
`endif

    // Pixel = column index.
    clear_mon();
    send_rows(2, 30);
    check_frame("col", 2);
    chk("col c8", (sums.size() > 21) ? sums[0] : -1, 324);
    chk("col c29", (sums.size() > 21) ? sums[21] : -1, 2025);
    chk("col row2 c8", (sums.size() > 22) ? sums[22] : -1, 324);

    // Pixel = row index.
    clear_mon();
    send_rows(3, 30);
    check_frame("row", 3);
    chk("row r8", (sums.size() > 0) ? sums[0] : -1, 324);
    chk("row r29", (sums.size() > 483) ? sums[483] : -1, 2025);

    // Abort after row 15, then a full frame.
    clear_mon();
    send_rows(0, 16);
    chk("abort count", sums.size(), 176);
    chk("abort done", done_idx.size(), 0);
    clear_mon();
    send_rows(0, 30);
    check_frame("restart", 0);

    // Reset asserted mid-frame.
    clear_mon();
    drive_rows(1, 12);
    @(negedge clk);
    chk("pre-rst valid", int'(valid_o), 1);
    rst    = 1'b1;
    done_i = 1'b0;
    #1;
    chk("mid-rst sum", int'(sum_o), 0);
    chk("mid-rst valid", int'(valid_o), 0);
    chk("mid-rst done", int'(done_o), 0);
    @(negedge clk);
    rst = 1'b0;
    clear_mon();
    send_rows(0, 30);
    check_frame("post-rst", 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
